// File: rtl/game_pkg.sv
// Shared constants for the obstacle lane: colours, draw windows, obstacle
// width, run-state encoding and the spawn LFSR seed.
package game_pkg;

    localparam logic [11:0] FLOOR_RGB = 12'h3A2;
    localparam logic [11:0] FLY_RGB   = 12'hC40;

    localparam logic [9:0]  FLOOR_Y0  = 10'd400;
    localparam logic [9:0]  FLOOR_Y1  = 10'd440;
    localparam logic [9:0]  FLY_Y0    = 10'd330;
    localparam logic [9:0]  FLY_Y1    = 10'd350;

    localparam logic [10:0] OBS_W     = 11'd30;

    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } run_state_t;

endpackage

// File: rtl/spawn_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that randomises respawn gap/type.
// Seeded non-zero, so it never reaches the all-zero lock-up state.
module spawn_lfsr
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (reset)
            value <= LFSR_SEED;
        else if (adv)
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end

endmodule

// File: rtl/obstacle_scroller.sv
// Scrolling obstacle slots with respawn, run/freeze control and pixel drawing.
// Define RANDOM_SPAWN_EN to randomise respawn gap and type with spawn_lfsr.
module obstacle_scroller
    import game_pkg::*;
#(
    parameter int N_OBS    = 4,
    parameter int SHIFT    = 5,
    parameter int INIT_X   = 250,
    parameter int INIT_GAP = 250,
    parameter int GAP_MIN  = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        hit,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        obs_pix,
    output logic [11:0] obs_rgb,
    output logic [1:0]  state,
    output logic [15:0] passed_cnt
);

    localparam logic [10:0] SHIFT_W = 11'(SHIFT);

    run_state_t       st;
    logic [10:0]      pos [N_OBS];
    logic [N_OBS-1:0] typ;
    logic             alt_typ;

    logic [10:0]      pos_nxt [N_OBS];
    logic [N_OBS-1:0] typ_nxt;
    logic             alt_nxt;
    logic [15:0]      cnt_nxt;
    logic [11:0]      gap;
    logic             advance;
    logic             do_init;
    logic             pix_c;
    logic [11:0]      rgb_c;

    assign state   = st;
    assign advance = (st == ST_RUN) && frame_tick && !hit;
    assign do_init = reset || ((st == ST_FROZEN) && start);

`ifdef RANDOM_SPAWN_EN
    logic [7:0] lfsr;

    spawn_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (advance),
        .value (lfsr)
    );

    assign gap = 12'(GAP_MIN) + {4'd0, lfsr};
`else
    assign gap = 12'(GAP_MIN + 128);
`endif

    // Slots still waiting to respawn sit at 0 so they never count as furthest;
    // respawns settle in index order, each seeing the ones before it.
    always_comb begin
        logic [10:0] furthest;
        logic [11:0] cand;
        furthest = '0;
        cand     = '0;
        typ_nxt  = typ;
        alt_nxt  = alt_typ;
        cnt_nxt  = passed_cnt;
        for (int i = 0; i < N_OBS; i++)
            pos_nxt[i] = (pos[i] < SHIFT_W) ? 11'd0 : pos[i] - SHIFT_W;
        for (int i = 0; i < N_OBS; i++) begin
            if (pos[i] < SHIFT_W) begin
                furthest = '0;
                for (int j = 0; j < N_OBS; j++)
                    if (pos_nxt[j] > furthest) furthest = pos_nxt[j];
                cand       = {1'b0, furthest} + gap;
                pos_nxt[i] = cand[11] ? 11'h7FF : cand[10:0];
`ifdef RANDOM_SPAWN_EN
                typ_nxt[i] = lfsr[0];
`else
                typ_nxt[i] = alt_nxt;
                alt_nxt    = ~alt_nxt;
`endif
                if (cnt_nxt != 16'hFFFF) cnt_nxt = cnt_nxt + 16'd1;
            end
        end
    end

    // Scanning from the highest index down lets the lowest covering slot win.
    always_comb begin
        logic xin;
        logic yin;
        xin   = 1'b0;
        yin   = 1'b0;
        pix_c = 1'b0;
        rgb_c = 12'h000;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            xin = ({1'b0, x} >= pos[i]) && ({1'b0, x} < pos[i] + OBS_W);
            yin = typ[i] ? ((y >= FLY_Y0) && (y < FLY_Y1))
                         : ((y >= FLOOR_Y0) && (y < FLOOR_Y1));
            if (xin && yin) begin
                pix_c = 1'b1;
                rgb_c = typ[i] ? FLY_RGB : FLOOR_RGB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= ST_IDLE;
            obs_pix <= 1'b0;
            obs_rgb <= 12'h000;
        end else begin
            obs_pix <= pix_c;
            obs_rgb <= rgb_c;
            case (st)
                ST_IDLE:   if (start) st <= ST_RUN;
                ST_RUN:    if (hit)   st <= ST_FROZEN;
                ST_FROZEN: if (start) st <= ST_RUN;
                default:   st <= ST_IDLE;
            endcase
        end

        if (do_init) begin
            for (int i = 0; i < N_OBS; i++) begin
                pos[i] <= 11'(INIT_X + i * INIT_GAP);
                typ[i] <= 1'(i % 2);
            end
            alt_typ    <= 1'b0;
            passed_cnt <= 16'd0;
        end else if (advance) begin
            pos        <= pos_nxt;
            typ        <= typ_nxt;
            alt_typ    <= alt_nxt;
            passed_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller (default build): directed pins plus randomised
// stimulus compared every cycle against a behavioural model of the lane.
module tb_obstacle_scroller;

    localparam int N   = 4;
    localparam int SH  = 5;
    localparam int GAP = 328;

    logic        clk = 1'b0;
    logic        reset, frame_tick, start, hit;
    logic [9:0]  x, y;
    logic        obs_pix;
    logic [11:0] obs_rgb;
    logic [1:0]  state;
    logic [15:0] passed_cnt;

    logic        pix2, pix3;
    logic [11:0] rgb2, rgb3;
    logic [1:0]  st2, st3;
    logic [15:0] cnt2, cnt3;

    obstacle_scroller dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .hit(hit),
        .x(x), .y(y), .obs_pix(obs_pix), .obs_rgb(obs_rgb), .state(state),
        .passed_cnt(passed_cnt)
    );

    // Two slots: slot 0 starts at 3, slot 1 at 995.
    obstacle_scroller #(.N_OBS(2), .INIT_X(3), .INIT_GAP(992)) dut2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .hit(hit),
        .x(x), .y(y), .obs_pix(pix2), .obs_rgb(rgb2), .state(st2),
        .passed_cnt(cnt2)
    );

    // Slots at 3,4,5,6: slots 0 and 1 both respawn on the first tick.
    obstacle_scroller #(.INIT_X(3), .INIT_GAP(1)) dut3 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .hit(hit),
        .x(x), .y(y), .obs_pix(pix3), .obs_rgb(rgb3), .state(st3),
        .passed_cnt(cnt3)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int m_pos [N];
    bit m_typ [N];
    int m_state, m_cnt, m_rgb;
    bit m_tog, m_pix;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic m_init();
        for (int i = 0; i < N; i++) begin
            m_pos[i] = 250 + i * 250;
            m_typ[i] = bit'(i % 2);
        end
        m_cnt = 0;
        m_tog = 1'b0;
    endtask

    function automatic bit covers(int p, bit t, int xx, int yy);
        bit in_y;
        in_y = t ? (yy >= 330 && yy < 350) : (yy >= 400 && yy < 440);
        return (xx >= p) && (xx < p + 30) && in_y;
    endfunction

    task automatic m_tick();
        bit gone [N];
        int np [N];
        int f;
        for (int i = 0; i < N; i++) begin
            gone[i] = m_pos[i] < SH;
            np[i]   = gone[i] ? 0 : m_pos[i] - SH;
        end
        for (int i = 0; i < N; i++) begin
            if (gone[i]) begin
                f = 0;
                for (int j = 0; j < N; j++)
                    if ((!gone[j] || j < i) && np[j] > f) f = np[j];
                np[i]    = (f + GAP > 2047) ? 2047 : f + GAP;
                m_typ[i] = m_tog;
                m_tog    = ~m_tog;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        for (int i = 0; i < N; i++) m_pos[i] = np[i];
    endtask

    task automatic m_step(bit r, bit s, bit h, bit t, int xx, int yy);
        if (r) begin
            m_init();
            m_state = 0;
            m_pix   = 1'b0;
            m_rgb   = 0;
            return;
        end
        m_pix = 1'b0;
        m_rgb = 0;
        for (int i = 0; i < N; i++) begin
            if (!m_pix && covers(m_pos[i], m_typ[i], xx, yy)) begin
                m_pix = 1'b1;
                m_rgb = m_typ[i] ? 'hC40 : 'h3A2;
            end
        end
        case (m_state)
            0: if (s) m_state = 1;
            1: if (h) m_state = 2; else if (t) m_tick();
            2: if (s) begin m_init(); m_state = 1; end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare();
        chk("state", int'(state), m_state);
        chk("passed_cnt", int'(passed_cnt), m_cnt);
        chk("obs_pix", int'(obs_pix), int'(m_pix));
        chk("obs_rgb", int'(obs_rgb), m_rgb);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("pos[%0d]", i), int'(dut.pos[i]), m_pos[i]);
            chk($sformatf("typ[%0d]", i), int'(dut.typ[i]), int'(m_typ[i]));
        end
    endtask

    task automatic cycle(bit r, bit s, bit h, bit t, int xx, int yy);
        reset = r; start = s; hit = h; frame_tick = t;
        x = 10'(xx); y = 10'(yy);
        @(posedge clk);
        #1;
        m_step(r, s, h, t, xx, yy);
        compare();
        @(negedge clk);
    endtask

    task automatic pin_pos(string tag, int p0, int p1, int p2, int p3);
        int e [N];
        e = '{p0, p1, p2, p3};
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s dut pos[%0d]", tag, i), int'(dut.pos[i]), e[i]);
            chk($sformatf("%s model pos[%0d]", tag, i), m_pos[i], e[i]);
        end
    endtask

    initial begin
        int xx, yy, k;
        reset = 1'b1; start = 1'b0; hit = 1'b0; frame_tick = 1'b0; x = '0; y = '0;

        // Reset, with start/hit/tick asserted to show reset wins.
        cycle(1, 1, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset state", int'(state), 0);
        chk("reset pix", int'(obs_pix), 0);
        chk("reset rgb", int'(obs_rgb), 0);
        pin_pos("reset", 250, 500, 750, 1000);

        // Drawing latency and y-window edge while idle.
        cycle(0, 0, 0, 0, 250, 420);
        chk("draw pix", int'(obs_pix), 1);
        chk("draw rgb", int'(obs_rgb), 'h3A2);
        cycle(0, 0, 0, 0, 250, 440);
        chk("draw y=440 pix", int'(obs_pix), 0);

        cycle(0, 1, 0, 0, 0, 0);
        chk("start state", int'(state), 1);
        cycle(0, 0, 0, 1, 0, 0);
        pin_pos("tick1", 245, 495, 745, 995);
        chk("dut2 respawn pos0", int'(dut2.pos[0]), 1318);
        chk("dut2 pos1", int'(dut2.pos[1]), 990);
        chk("dut2 passed", int'(cnt2), 1);
        chk("dut3 pos0", int'(dut3.pos[0]), 329);
        chk("dut3 pos1", int'(dut3.pos[1]), 657);
        chk("dut3 pos2", int'(dut3.pos[2]), 0);
        chk("dut3 typ1", int'(dut3.typ[1]), 1);
        chk("dut3 passed", int'(cnt3), 2);

        for (int i = 0; i < 50; i++) cycle(0, 0, 0, 1, 0, 0);
        pin_pos("tick51", 1073, 245, 495, 745);
        chk("tick51 passed", int'(passed_cnt), 1);

        cycle(0, 0, 1, 1, 0, 0);
        chk("hit state", int'(state), 2);
        pin_pos("hit", 1073, 245, 495, 745);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0);
        pin_pos("frozen", 1073, 245, 495, 745);

        cycle(0, 1, 0, 1, 0, 0);
        chk("restart state", int'(state), 1);
        chk("restart passed", int'(passed_cnt), 0);
        pin_pos("restart", 250, 500, 750, 1000);

        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(1)) begin
                k  = $urandom_range(N - 1);
                xx = m_pos[k] - 3 + $urandom_range(35);
                if (xx < 0 || xx > 1023) xx = $urandom_range(1023);
            end else begin
                xx = $urandom_range(1023);
            end
            case ($urandom_range(2))
                0:       yy = $urandom_range(479);
                1:       yy = 328 + $urandom_range(24);
                default: yy = 398 + $urandom_range(44);
            endcase
            cycle($urandom_range(1999) == 0, $urandom_range(149) == 0,
                  $urandom_range(399) == 0, $urandom_range(2) == 0, xx, yy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/obstacle_scroller.md
OBSTACLE_SCROLLER -- requirements
Module: obstacle_scroller

Interface
REQ-001 SHALL have parameter N_OBS, 4, number of obstacle slots (2..8).
REQ-002 SHALL have parameter SHIFT, 5, pixels moved left per frame_tick (1..15).
REQ-003 SHALL have parameter INIT_X, 250, x of slot 0 after init.
REQ-004 SHALL have parameter INIT_GAP, 250, x spacing between consecutive slots after init.
REQ-005 SHALL have parameter GAP_MIN, 200, minimum respawn gap in pixels.
REQ-006 SHALL have port clk input 1, system clock.
REQ-007 SHALL have port reset input 1, synchronous, active-high.
REQ-008 SHALL have port frame_tick input 1, one-cycle pulse per video frame.
REQ-009 SHALL have port start input 1, one-cycle pulse that starts or restarts the run.
REQ-010 SHALL have port hit input 1, one-cycle collision pulse from the player logic.
REQ-011 SHALL have ports x, y input 10 each, current scan pixel.
REQ-012 SHALL have port obs_pix output 1, pixel lies inside any obstacle.
REQ-013 SHALL have port obs_rgb output 12, colour of the topmost covering obstacle, 12'h000 if none.
REQ-014 SHALL have port state output 2, 0 IDLE, 1 RUN, 2 FROZEN.
REQ-015 SHALL have port passed_cnt output 16, obstacles that have scrolled off-screen during RUN.

Function
REQ-016 SHALL hold per slot an unsigned 11-bit left-edge position pos[i] and a 1-bit type typ[i] (0 floor, 1 flying).
REQ-017 SHALL perform init as: pos[i] = INIT_X + i*INIT_GAP; typ[i] = i mod 2; passed_cnt = 0.
REQ-018 SHALL use state IDLE -> RUN on start; RUN -> FROZEN on hit; FROZEN -> RUN on start, with init applied in the same cycle.
REQ-019 SHALL ignore start in RUN and ignore hit outside RUN.
REQ-020 SHALL move obstacles only in RUN on frame_tick: pos[i] = pos[i] - SHIFT.
REQ-021 SHALL give hit priority over a same-cycle frame_tick: the state enters FROZEN and nothing moves.
REQ-022 SHALL respawn any slot with pos[i] < SHIFT at that tick, in place of moving it, and increment passed_cnt by 1.
REQ-023 SHALL compute the respawn position as furthest + gap, where furthest is the maximum post-tick pos over all slots, and saturate the result at 2047.
REQ-024 SHALL process multiple respawns in the same tick in ascending index order; each later slot's furthest includes earlier respawned slots.
REQ-025 SHALL saturate passed_cnt at 16'hFFFF.
REQ-026 SHALL test an x-window for both obstacle types: pos[i] <= x < pos[i]+30, compared on 11 bits.
REQ-027 SHALL test a y-window of 400 <= y < 440 for floor obstacles and 330 <= y < 350 for flying obstacles.
REQ-028 SHALL register obs_pix and obs_rgb with exactly 1 clk latency from x/y.
REQ-029 SHALL resolve overlapping obstacles to the lowest slot index.
REQ-030 SHALL use colour FLOOR_RGB for floor obstacles and FLY_RGB for flying obstacles.
REQ-031 SHALL keep drawing in IDLE and FROZEN, using the held positions.

Reset
REQ-032 SHALL on reset apply init, set state IDLE and clear obs_pix and obs_rgb to 0; reset overrides start, hit and frame_tick.
REQ-033 SHALL reseed the LFSR to 8'hA5 on reset; the LFSR is never all-zero.

Configuration
REQ-034 SHALL, with RANDOM_SPAWN_EN defined, use an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advanced once per frame_tick in RUN, with gap = GAP_MIN + lfsr and respawned typ = lfsr[0].
REQ-035 SHALL, without RANDOM_SPAWN_EN, use gap = GAP_MIN + 128 with respawned typ alternating per respawn event starting at 0; no LFSR is instantiated.

Structure
REQ-036 SHALL place FLOOR_RGB (12'h3A2), FLY_RGB (12'hC40), the y-window bounds, obstacle width 30, the state encodings and the LFSR seed in shared package game_pkg.
REQ-037 SHALL implement the LFSR as sub-module spawn_lfsr (clk, reset, adv, value[7:0]).

Verification
REQ-038 SHALL verify: reset, then start, then 1 tick with defaults -> pos = 245/495/745/995, state 1.
REQ-039 SHALL verify: with pos[0] = 3, tick -> slot 0 respawns at 990 + gap and passed_cnt = 1 (no-macro gap 328 -> 1318).
REQ-040 SHALL verify: hit and frame_tick in the same cycle -> state 2 and positions unchanged on the next cycle and on later ticks.
REQ-041 SHALL verify: in FROZEN, start -> positions re-initialised to 250/500/750/1000, passed_cnt 0, state 1.
REQ-042 SHALL verify: x = 250, y = 420 with slot 0 floor at 250 -> obs_pix = 1 and obs_rgb = 12'h3A2 exactly one clk later; at y = 440 -> 0.
REQ-043 SHALL verify: two slots with pos < SHIFT in one tick -> the higher index spawns beyond the lower index's new position.
